// File: rtl/s3_writeback.sv
// s3_writeback: final pipeline stage. Registers the s2 instruction, extracts load
// data, selects the register-file write value and keeps the cycle/instret counters.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   stall                hold s3 registers (no s2->s3 transfer)
//   valid_s2             s2 holds a real instruction
//   instruction_s2       instruction word in s2
//   alu_result_s2        ALU result or load/store effective address
//   pc_s2                PC of the s2 instruction
//   mem_rdata            synchronous memory read data for the load in s3
//   counter_rst          clear both counters
//   instruction_s3       retiring instruction (NOP_INST when invalid)
//   wb_data/rf_we/rf_wa  register-file write port
//   cycle_count          cycles since reset or counter_rst
//   instret_count        instructions retired since reset or counter_rst
module s3_writeback #(
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        valid_s2,
   input  logic [31:0] instruction_s2,
   input  logic [31:0] alu_result_s2,
   input  logic [31:0] pc_s2,
   input  logic [31:0] mem_rdata,
   input  logic        counter_rst,
   output logic [31:0] instruction_s3,
   output logic [31:0] wb_data,
   output logic        rf_we,
   output logic [4:0]  rf_wa,
   output logic [31:0] cycle_count,
   output logic [31:0] instret_count
);

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;

   logic [31:0] inst_q;
   logic [31:0] alu_q;
   logic [31:0] pc_q;
   logic        valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         inst_q  <= NOP_INST;
         alu_q   <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else if (!stall) begin
         inst_q  <= valid_s2 ? instruction_s2 : NOP_INST;
         alu_q   <= alu_result_s2;
         pc_q    <= pc_s2;
         valid_q <= valid_s2;
      end
   end

   // A retirement coinciding with counter_rst is deliberately dropped.
   always_ff @(posedge clk) begin
      if (rst || counter_rst) begin
         cycle_count   <= '0;
         instret_count <= '0;
      end else begin
         cycle_count <= cycle_count + 32'd1;
         if (valid_q && !stall)
            instret_count <= instret_count + 32'd1;
      end
   end

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [1:0]  off;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

   assign opcode = inst_q[6:0];
   assign funct3 = inst_q[14:12];
   assign off    = alu_q[1:0];

   always_comb begin
      ld_byte = mem_rdata[{off, 3'b000} +: 8];
      ld_half = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (funct3)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {24'h0, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'h0, ld_half};
         default: ld_data = mem_rdata;
      endcase
   end

   logic is_load;
   logic is_link;
   logic is_alu;

   assign is_load = (opcode == OPC_LOAD);
   assign is_link = (opcode == OPC_JAL) || (opcode == OPC_JALR);
   assign is_alu  = (opcode == OPC_ARI_RTYPE) || (opcode == OPC_ARI_ITYPE)
                 || (opcode == OPC_LUI) || (opcode == OPC_AUIPC);

   always_comb begin
      wb_data = alu_q;
      unique case (1'b1)
         is_load: wb_data = ld_data;
         is_link: wb_data = pc_q + 32'd4;
         default: wb_data = alu_q;
      endcase
   end

   assign instruction_s3 = inst_q;
   assign rf_wa          = inst_q[11:7];
   // Not gated by stall: a held write rewrites the same value.
   assign rf_we = valid_q && (rf_wa != 5'd0) && (is_load || is_link || is_alu);

endmodule
